// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared constants and helpers for the pipelined carry-lookahead adder.
//   GROUP_DEFAULT : default number of bits per lookahead group / pipe stage
//   nstage()      : pipeline depth for a given WIDTH and GROUP
//   width_ok()    : legality of a WIDTH/GROUP pair, used at elaboration
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int GROUP_DEFAULT = 4;

    // One lookahead group per pipeline stage.
    function automatic int nstage(input int width, input int group);
        return width / group;
    endfunction

    // WIDTH must be a whole number of groups, and at least one group.
    function automatic bit width_ok(input int width, input int group);
        return (group > 0) && (width >= group) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder_if
// Operand and result streams of cla_pipe_adder.
//   in_valid/in_ready   : operand beat handshake
//   a, b, cin, sub      : operands, carry-in, subtract select
//   out_valid/out_ready : result beat handshake
//   sum, cout, ovf      : result, carry out of MSB, signed overflow
// Modports: master = operand source / result consumer, slave = the adder.
// -----------------------------------------------------------------------------
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/cla_pipe_adder_group.sv
// -----------------------------------------------------------------------------
// cla_group
// Combinational GROUP-bit carry-lookahead adder. Every internal carry is a
// sum of products of p, g and ci, so there is no ripple inside the group.
//   a, b  : GROUP-bit operands
//   ci    : carry into bit 0
//   s     : GROUP-bit sum
//   co    : carry out of the top bit
//   c_msb : carry into the top bit (needed for signed overflow)
// -----------------------------------------------------------------------------
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = GROUP_DEFAULT
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             chain;

    assign p = a ^ b;
    assign g = a & b;

    // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i]..p[0]ci
    always_comb begin
        // NOTE: every variable written here gets a default first, so no
        // path through the loops can leave it unassigned and infer a latch.
        c     = '0;
        chain = 1'b0;
        c[0]  = ci;
        for (int i = 0; i < GROUP; i++) begin
            // NOTE: blocking assignments are correct in combinational logic;
            // 'chain' accumulates the propagate product within one evaluation.
            c[i+1] = g[i];
            chain  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (chain & g[j]);
                chain  = chain & p[j];
            end
            c[i+1] = c[i+1] | (chain & ci);
        end
    end

    assign s     = p ^ c[GROUP-1:0];
    assign co    = c[GROUP];
    assign c_msb = c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
// Pipelined carry-lookahead adder/subtractor. Stage k adds bit group k, so a
// WIDTH-bit operation takes NSTAGE = WIDTH/GROUP cycles and the pipe accepts
// one operation per cycle. All stages advance together on adv.
//   clk : rising-edge clock
//   rst : synchronous, active-high reset; discards everything in flight
//   bus : cla_pipe_adder_if.slave (operand stream in, result stream out)
// sub=1 computes a-b as a+~b+1 (cin ignored); cout=1 then means no borrow.
// ovf is carry into the MSB XOR carry out of the MSB.
// -----------------------------------------------------------------------------
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = GROUP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    cla_pipe_adder_if.slave bus
);

    localparam int NSTAGE = nstage(WIDTH, GROUP);

    if (!width_ok(WIDTH, GROUP)) begin : g_param_check
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
    end

    logic             adv;
    logic             accept;
    logic             out_valid;
    logic [WIDTH-1:0] b_eff;
    logic             c_first;
    logic             stage_cmsb [NSTAGE];

    // The whole pipe moves unless a finished result is waiting to be taken;
    // a bubble in the output stage never blocks the fill.
    assign out_valid = g_stage[NSTAGE-1].valid_q;
    assign adv       = ~out_valid | bus.out_ready;
    assign accept    = bus.in_valid & adv;

    // Subtraction as a + ~b + 1; the forced carry-in overrides cin.
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign c_first = bus.sub | bus.cin;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        localparam int IW = WIDTH - k * GROUP;   // operand bits still to add
        localparam int SW = (k + 1) * GROUP;     // sum bits known after stage

        logic [IW-1:0]    opa_in;
        logic [IW-1:0]    opb_in;
        logic             ci_in;
        logic             v_in;
        logic [GROUP-1:0] gs;
        logic             gco;
        logic [SW-1:0]    sum_next;
        logic             valid_q;
        logic             carry_q;
        logic [SW-1:0]    sum_q;

        if (k == 0) begin : g_src
            assign opa_in   = bus.a;
            assign opb_in   = b_eff;
            assign ci_in    = c_first;
            assign v_in     = accept;
            assign sum_next = gs;
        end else begin : g_src
            assign opa_in   = g_stage[k-1].g_mid.opa_q;
            assign opb_in   = g_stage[k-1].g_mid.opb_q;
            assign ci_in    = g_stage[k-1].carry_q;
            assign v_in     = g_stage[k-1].valid_q;
            assign sum_next = {gs, g_stage[k-1].sum_q};
        end

        cla_group #(
            .GROUP (GROUP)
        ) u_group (
            .a     (opa_in[GROUP-1:0]),
            .b     (opb_in[GROUP-1:0]),
            .ci    (ci_in),
            .s     (gs),
            .co    (gco),
            .c_msb (stage_cmsb[k])
        );

        // Valid bits advance on every adv so bubbles travel with the data.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
            end else if (adv) begin
                valid_q <= v_in;
            end
        end

        if (k < NSTAGE - 1) begin : g_mid
            logic [IW-GROUP-1:0] opa_q;
            logic [IW-GROUP-1:0] opb_q;

            // NOTE: intermediate payload registers carry no reset; the valid
            // bits alone decide whether their contents mean anything, which
            // keeps the wide datapath free of reset fan-out.
            always_ff @(posedge clk) begin
                if (adv && v_in) begin
                    opa_q   <= opa_in[IW-1:GROUP];
                    opb_q   <= opb_in[IW-1:GROUP];
                    sum_q   <= sum_next;
                    carry_q <= gco;
                end
            end
        end else begin : g_last
            logic cmsb_q;

            // The output stage is visible on the ports, so it resets to 0.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sum_q   <= '0;
                    carry_q <= 1'b0;
                    cmsb_q  <= 1'b0;
                end else if (adv && v_in) begin
                    sum_q   <= sum_next;
                    carry_q <= gco;
                    cmsb_q  <= stage_cmsb[k];
                end
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid;
    assign bus.sum       = g_stage[NSTAGE-1].sum_q;
    assign bus.cout      = g_stage[NSTAGE-1].carry_q;
    assign bus.ovf       = g_stage[NSTAGE-1].g_last.cmsb_q ^ g_stage[NSTAGE-1].carry_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
// Self-checking bench for cla_pipe_adder: a 16/4 instance for the main
// scenarios plus 8/8 and 32/4 instances for the re-parametrised cases.
// Expected results come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;

    localparam int W  = 16;
    localparam int G  = 4;
    localparam int NS = W / G;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;   // edge at which the beat was accepted
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(16)) bus   ();
    cla_pipe_adder_if #(.WIDTH(8))  bus8  ();
    cla_pipe_adder_if #(.WIDTH(32)) bus32 ();

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut   (.clk(clk), .rst(rst), .bus(bus));
    cla_pipe_adder #(.WIDTH(8),  .GROUP(8)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
    cla_pipe_adder #(.WIDTH(32), .GROUP(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    // Reference: unsigned and signed integer arithmetic on the operands.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub, input int acc);
        exp_t r;
        int   ua, ub, sa, sb, full, sres;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            full   = ua - ub;
            sres   = sa - sb;
            r.cout = (ua >= ub);
        end else begin
            full   = ua + ub + int'(cin);
            sres   = sa + sb + int'(cin);
            r.cout = (full > 65535);
        end
        r.sum = full[15:0];
        r.ovf = (sres > 32767) || (sres < -32768);
        r.acc = acc;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic ordy);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.sub       = sub;
        bus.out_ready = ordy;
        #1;
    endtask

    // Bookkeeping for the edge about to happen: pop the leaving result,
    // push the model of an entering beat. Comparisons stay in the tests.
    task automatic handshake(output logic popped, output exp_t e, output logic orphan);
        popped = 1'b0;
        orphan = 1'b0;
        e      = '{16'h0, 1'b0, 1'b0, 0};
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) orphan = 1'b1;
            else begin
                e      = exp_q.pop_front();
                popped = 1'b1;
            end
        end
        if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub, cyc + 1));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        n_cmp += 7;
        if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        if (bus.sum !== 16'h0)      begin n_bad++; $display("FAIL reset_sum: got %h want 0000", bus.sum); end
        if (bus.cout !== 1'b0)      begin n_bad++; $display("FAIL reset_cout: got %b want 0", bus.cout); end
        if (bus.ovf !== 1'b0)       begin n_bad++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
        if (bus.in_ready !== 1'b1)  begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        if (bus8.out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_out_valid_w8: got %b want 0", bus8.out_valid); end
        if (bus32.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_w32: got %b want 0", bus32.out_valid); end
    endtask

    task automatic test_directed();
        logic [15:0] ta [3] = '{16'hFFFF, 16'h7FFF, 16'h0005};
        logic [15:0] tb [3] = '{16'h0001, 16'h0001, 16'h0007};
        logic        ts [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] ws [3] = '{16'h0000, 16'h8000, 16'hFFFE};
        logic        wc [3] = '{1'b1, 1'b0, 1'b0};
        logic        wo [3] = '{1'b0, 1'b1, 1'b0};
        int   got = 0;
        logic p, o;
        exp_t e;
        for (int i = 0; i < 30 && got < 3; i++) begin
            if (i < 3) drive(1'b1, ta[i], tb[i], 1'b0, ts[i], 1'b1);
            else       drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            handshake(p, e, o);
            if (o) begin n_cmp++; n_bad++; $display("FAIL directed_extra: unexpected result %h", bus.sum); end
            if (p) begin
                n_cmp += 2;
                if ({bus.sum, bus.cout, bus.ovf} !== {ws[got], wc[got], wo[got]}) begin
                    n_bad++;
                    $display("FAIL directed_%0d: got %h/%b/%b want %h/%b/%b", got,
                             bus.sum, bus.cout, bus.ovf, ws[got], wc[got], wo[got]);
                end
                if (cyc - e.acc + 1 != NS) begin
                    n_bad++;
                    $display("FAIL directed_latency_%0d: got %0d want %0d", got, cyc - e.acc + 1, NS);
                end
                got++;
            end
            tick();
        end
        n_cmp++;
        if (got != 3) begin n_bad++; $display("FAIL directed_count: got %0d want 3", got); end
    endtask

    task automatic test_back_to_back();
        int   sent = 0;
        int   got  = 0;
        logic p, o;
        exp_t e;
        logic [31:0] ra, rb;
        logic        rc, rs;
        for (int i = 0; i < 150 && got < 100; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            if (sent % 10 == 3) begin rc = 1'b1; rs = 1'b1; end
            drive(sent < 100, ra[15:0], rb[15:0], rc, rs, 1'b1);
            if (sent < 100) begin
                n_cmp++;
                if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready); end
            end
            handshake(p, e, o);
            if (o) begin n_cmp++; n_bad++; $display("FAIL b2b_extra: unexpected result %h", bus.sum); end
            if (p) begin
                n_cmp += 2;
                if ({bus.sum, bus.cout, bus.ovf} !== {e.sum, e.cout, e.ovf}) begin
                    n_bad++;
                    $display("FAIL b2b_result_%0d: got %h/%b/%b want %h/%b/%b", got,
                             bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
                end
                if (cyc - e.acc + 1 != NS) begin
                    n_bad++;
                    $display("FAIL b2b_latency_%0d: got %0d want %0d", got, cyc - e.acc + 1, NS);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        n_cmp++;
        if (got != 100) begin n_bad++; $display("FAIL b2b_count: got %0d want 100", got); end
    endtask

    task automatic test_stall();
        logic [15:0] va [6];
        logic [15:0] vb [6];
        logic        vc [6];
        logic        vs [6];
        logic [17:0] snap = '0;
        logic        have_snap = 1'b0;
        logic        ordy;
        int   sent = 0;
        int   got  = 0;
        int   stall = 0;
        int   idx;
        logic p, o;
        exp_t e;
        logic [31:0] r;
        for (int i = 0; i < 6; i++) begin
            r = $urandom; va[i] = r[15:0];
            r = $urandom; vb[i] = r[15:0];
            vc[i] = 1'($urandom_range(0, 1));
            vs[i] = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 60 && got < 6; i++) begin
            ordy = (stall >= 3);
            idx  = (sent < 6) ? sent : 0;
            drive(sent < 6, va[idx], vb[idx], vc[idx], vs[idx], ordy);
            if (bus.out_valid && !ordy) begin
                n_cmp++;
                if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %b want 0", bus.in_ready); end
                if (!have_snap) begin
                    snap      = {bus.sum, bus.cout, bus.ovf};
                    have_snap = 1'b1;
                end else begin
                    n_cmp++;
                    if ({bus.sum, bus.cout, bus.ovf} !== snap) begin
                        n_bad++;
                        $display("FAIL stall_hold: got %h want %h", {bus.sum, bus.cout, bus.ovf}, snap);
                    end
                end
                stall++;
            end
            handshake(p, e, o);
            if (o) begin n_cmp++; n_bad++; $display("FAIL stall_extra: unexpected result %h", bus.sum); end
            if (p) begin
                n_cmp++;
                if ({bus.sum, bus.cout, bus.ovf} !== {e.sum, e.cout, e.ovf}) begin
                    n_bad++;
                    $display("FAIL stall_result_%0d: got %h/%b/%b want %h/%b/%b", got,
                             bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            tick();
        end
        n_cmp += 2;
        if (got != 6)   begin n_bad++; $display("FAIL stall_count: got %0d want 6", got); end
        if (stall != 3) begin n_bad++; $display("FAIL stall_cycles: got %0d want 3", stall); end
    endtask

    task automatic test_reset_flush();
        int   got = 0;
        logic p, o;
        exp_t e;
        logic [31:0] ra, rb;
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom;
            drive(1'b1, ra[15:0], rb[15:0], 1'b0, 1'b0, 1'b1);
            handshake(p, e, o);
            tick();
        end
        rst = 1'b1;
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        tick();
        n_cmp += 4;
        if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_out_valid: got %b want 0", bus.out_valid); end
        if (bus.sum !== 16'h0)      begin n_bad++; $display("FAIL flush_sum: got %h want 0000", bus.sum); end
        if (bus.cout !== 1'b0)      begin n_bad++; $display("FAIL flush_cout: got %b want 0", bus.cout); end
        if (bus.ovf !== 1'b0)       begin n_bad++; $display("FAIL flush_ovf: got %b want 0", bus.ovf); end
        exp_q.delete();
        rst = 1'b0;
        for (int i = 0; i < NS + 3; i++) begin
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ghost: out_valid %b want 0", bus.out_valid); end
            tick();
        end
        ra = $urandom;
        rb = $urandom;
        for (int i = 0; i < 20 && got < 1; i++) begin
            if (i == 0) drive(1'b1, ra[15:0], rb[15:0], 1'b1, 1'b0, 1'b1);
            else        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
            handshake(p, e, o);
            if (o) begin n_cmp++; n_bad++; $display("FAIL flush_extra: unexpected result %h", bus.sum); end
            if (p) begin
                n_cmp += 2;
                if ({bus.sum, bus.cout, bus.ovf} !== {e.sum, e.cout, e.ovf}) begin
                    n_bad++;
                    $display("FAIL flush_fresh: got %h/%b/%b want %h/%b/%b",
                             bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
                end
                if (cyc - e.acc + 1 != NS) begin
                    n_bad++;
                    $display("FAIL flush_latency: got %0d want %0d", cyc - e.acc + 1, NS);
                end
                got++;
            end
            tick();
        end
        n_cmp++;
        if (got != 1) begin n_bad++; $display("FAIL flush_count: got %0d want 1", got); end
    endtask

    task automatic test_params();
        int n;
        // WIDTH=8, GROUP=8: single stage, latency 1.
        bus8.in_valid = 1'b1; bus8.a = 8'h80; bus8.b = 8'h80;
        bus8.cin = 1'b0; bus8.sub = 1'b0; bus8.out_ready = 1'b1;
        #1;
        n_cmp++;
        if (bus8.in_ready !== 1'b1) begin n_bad++; $display("FAIL w8_in_ready: got %b want 1", bus8.in_ready); end
        tick();
        bus8.in_valid = 1'b0;
        n = 1;
        while (bus8.out_valid !== 1'b1 && n < 30) begin tick(); n++; end
        n_cmp += 2;
        if (n != 1) begin n_bad++; $display("FAIL w8_latency: got %0d want 1", n); end
        if ({bus8.sum, bus8.cout, bus8.ovf} !== {8'h00, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL w8_result: got %h/%b/%b want 00/1/1", bus8.sum, bus8.cout, bus8.ovf);
        end
        // WIDTH=32, GROUP=4: eight stages, latency 8.
        bus32.in_valid = 1'b1; bus32.a = 32'h8000_0000; bus32.b = 32'h8000_0000;
        bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;
        #1;
        tick();
        bus32.in_valid = 1'b0;
        n = 1;
        while (bus32.out_valid !== 1'b1 && n < 30) begin tick(); n++; end
        n_cmp += 2;
        if (n != 8) begin n_bad++; $display("FAIL w32_latency: got %0d want 8", n); end
        if ({bus32.sum, bus32.cout, bus32.ovf} !== {32'h0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL w32_result: got %h/%b/%b want 00000000/1/1", bus32.sum, bus32.cout, bus32.ovf);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid   = 1'b0; bus.a   = '0; bus.b   = '0; bus.cin   = 1'b0; bus.sub   = 1'b0; bus.out_ready   = 1'b1;
        bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.sub  = 1'b0; bus8.out_ready  = 1'b1;
        bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_flush();
        test_params();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor. Splits a WIDTH-bit operation into GROUP-bit lookahead groups and processes one group per pipeline stage, so throughput is one operation per clock at any width. Sits between operand sources and result consumers on valid/ready streams, and replaces the fixed 4-bit combinational CLA wherever wide or high-frequency arithmetic is needed.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of GROUP, minimum GROUP.
- GROUP, 4, bits per lookahead group; each group occupies one pipeline stage.
- NSTAGE (localparam), WIDTH/GROUP, pipeline depth.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts the beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB; for sub, 1 means no borrow.
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- Stage k (0..NSTAGE-1) adds bits [k*GROUP +: GROUP] with full lookahead: p=a^b, g=a&b, all group carries formed from p, g and the incoming carry, with no internal ripple.
- Stage k registers: its group sum, its carry-out, all operand slices not yet consumed (upper slices still to add), all lower sum slices already produced, a valid bit, and the carry into the top bit (last stage only, for ovf).
- Stage 0 applies the sub transform: b'=~b and carry-in=1 when sub=1, else b'=b and carry-in=cin.
- Global advance enable: adv = ~out_valid | out_ready. When adv=1, every stage shifts forward one position. When adv=0, all stage registers hold.
- in_ready = adv. A beat is accepted when in_valid & in_ready.
- Bubbles propagate as valid=0 stages. Bubbles are not compressed.
- sum, cout and ovf are the registered contents of the final stage. They are meaningful only while out_valid=1 and hold steady while out_valid & ~out_ready.
- Results emerge in strict acceptance order.

## Timing
- Latency: an operation accepted at edge t appears at out_valid after edge t+NSTAGE-1, i.e. NSTAGE cycles.
  - NSTAGE=1 degenerates to a registered single-group CLA with latency 1.
- Throughput: one result per cycle while out_ready=1.
- Reset: all stage valid bits clear. out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 in the first cycle after reset.
- Reset asserted mid-stream discards all in-flight operations. No partial result is emitted.
- Simultaneous out_ready=1 with the output stage full and in_valid=1: the result leaves and the new beat enters in the same edge, so a full pipeline streams without a gap.
- out_ready low while out_valid=0 does not stall the pipeline, because adv=1. This lets the pipeline fill.
- Wrap-around: the sum is modulo 2^WIDTH, with the carry reported only on cout.

## Structure
- Sub-module cla_group: a combinational GROUP-bit lookahead adder. Inputs: GROUP-bit a, GROUP-bit b, and ci. Outputs: GROUP-bit s, co, and c_msb (the carry into its top bit). It is instantiated once per stage via generate.
- A shared package cla_pkg holds:
  - the default GROUP constant;
  - a function returning NSTAGE;
  - an elaboration-time check that WIDTH % GROUP == 0.
- No state machine beyond the per-stage valid bits and the global adv enable.

## Test plan
- WIDTH=16: a=0xFFFF, b=0x0001, cin=0, sub=0 → 4 cycles later sum=0x0000, cout=1, ovf=0.
- a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, cout=0, ovf=1. Then a=0x0005, b=0x0007, sub=1 on the next cycle → sum=0xFFFE, cout=0, ovf=0.
- Back-to-back stream of 100 random beats with out_ready=1 → in_ready stays 1, one result per cycle, each matching the (a+b+cin) or (a-b) model. Include cin=1 with sub=1 to confirm cin is ignored.
- Accept 6 beats, then hold out_ready=0 for 3 cycles once out_valid=1 → sum, cout and ovf stay stable and in_ready=0 during the stall. After release, all 6 results arrive in order with none lost or duplicated.
- Assert rst for 1 cycle with 3 beats in flight → out_valid=0 and all outputs 0 the next cycle. None of the 3 results ever appear, and a fresh beat accepted afterwards returns correctly after NSTAGE cycles.
- Re-parametrise to WIDTH=8, GROUP=8 and WIDTH=32, GROUP=4. Drive a=0x80…0 and b=0x80…0 → sum=0, cout=1, ovf=1, after 1 and 8 cycles respectively.
